// File: rtl/dma_arb_pkg.sv
// Shared types and constants for the DMA request arbiter: FSM state encoding,
// select-width helper and default timing parameters.
package dma_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACTIVE,
        ST_DONE,
        ST_GUARD
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ        = 4;
    localparam int unsigned DEF_GUARD_CYCLES   = 2;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

    // Width needed to index n items; never narrower than one bit.
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dma_req_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or above
// ptr, wrapping from NUM_REQ-1 back to 0.
module rr_pick
    import dma_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned SEL_W   = sel_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               valid,
    output logic [SEL_W-1:0]   index
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        valid = 1'b0;
        index = '0;
        // Walk offsets from farthest to nearest so the nearest hit wins last.
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            int j;
            j = (int'(ptr) + i) % int'(NUM_REQ);
            if (req[j]) begin
                valid = 1'b1;
                index = SEL_W'(j);
            end
        end
    end

endmodule

// File: rtl/dma_req_arbiter.sv
// Round-robin arbiter sharing one ASSP DMA channel among NUM_REQ requesters.
// Optional watchdog enabled by defining DMA_REQ_ARBITER_TIMEOUT_EN.
module dma_req_arbiter
    import dma_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
    parameter int unsigned GUARD_CYCLES   = DEF_GUARD_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [NUM_REQ-1:0]         done_o,
    output logic [sel_w(NUM_REQ)-1:0]  sel_o,
    output logic                       busy_o,
    output logic                       DMA_REQ_o,
    input  logic                       DMA_Active_i,
    input  logic                       ASSP_DMA_Done_i,
    output logic                       err_o
);

    localparam int unsigned SEL_W = sel_w(NUM_REQ);
    localparam int unsigned GW    = sel_w(GUARD_CYCLES);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    logic [GW-1:0]      guard_q, guard_d;
    logic               dma_req_q, dma_req_d;
    logic               busy_q;

    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic               timeout_hit;
    logic [SEL_W-1:0]   sel_next;
    arb_state_e         after_xfer;

    rr_pick #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_rr_pick (
        .req   (req_i),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .index (pick_idx)
    );

    assign sel_next   = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + SEL_W'(1);
    assign after_xfer = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        done_d    = '0;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        guard_d   = guard_q;
        dma_req_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d          = ST_REQ;
                    gnt_d            = '0;
                    gnt_d[pick_idx]  = 1'b1;
                    sel_d            = pick_idx;
                    dma_req_d        = 1'b1;
                end
            end
            ST_REQ, ST_ACTIVE: begin
                // Done wins over both a late Active and the watchdog.
                if (ASSP_DMA_Done_i) begin
                    state_d       = ST_DONE;
                    done_d[sel_q] = 1'b1;
                    ptr_d         = sel_next;
                end else if (timeout_hit) begin
                    state_d = after_xfer;
                    gnt_d   = '0;
                    guard_d = '0;
                    ptr_d   = sel_next;
                end else if (state_q == ST_REQ && !DMA_Active_i) begin
                    dma_req_d = 1'b1;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_DONE: begin
                state_d = after_xfer;
                gnt_d   = '0;
                guard_d = '0;
            end
            ST_GUARD: begin
                if (guard_q == GW'(GUARD_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            done_q    <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            guard_q   <= '0;
            dma_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            guard_q   <= guard_d;
            dma_req_q <= dma_req_d;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

`ifdef DMA_REQ_ARBITER_TIMEOUT_EN
    localparam int unsigned TW = sel_w(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    assign timeout_hit = (state_q == ST_REQ || state_q == ST_ACTIVE) &&
                         (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q == ST_REQ || state_q == ST_ACTIVE) begin
            tmo_d = tmo_q + TW'(1);
        end
        if (state_d == ST_REQ && state_q != ST_REQ) begin
            tmo_d = '0;
        end
        if (timeout_hit && !ASSP_DMA_Done_i) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err_o       = 1'b0;
`endif

    assign gnt_o     = gnt_q;
    assign done_o    = done_q;
    assign sel_o     = sel_q;
    assign busy_o    = busy_q;
    assign DMA_REQ_o = dma_req_q;

endmodule

// File: tb/tb_dma_req_arbiter.sv
// Directed, table-driven bench for dma_req_arbiter (NUM_REQ=4, GUARD_CYCLES=2);
// the watchdog sequence follows DMA_REQ_ARBITER_TIMEOUT_EN.
module tb_dma_req_arbiter;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [3:0] req_i;
    logic [3:0] gnt_o;
    logic [3:0] done_o;
    logic [1:0] sel_o;
    logic       busy_o;
    logic       DMA_REQ_o;
    logic       DMA_Active_i;
    logic       ASSP_DMA_Done_i;
    logic       err_o;

    int n_checks = 0;
    int n_fail   = 0;

    dma_req_arbiter #(
        .NUM_REQ        (4),
        .GUARD_CYCLES   (2),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_i           (req_i),
        .gnt_o           (gnt_o),
        .done_o          (done_o),
        .sel_o           (sel_o),
        .busy_o          (busy_o),
        .DMA_REQ_o       (DMA_REQ_o),
        .DMA_Active_i    (DMA_Active_i),
        .ASSP_DMA_Done_i (ASSP_DMA_Done_i),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] req;
        logic       act;
        logic       dn;
        logic [3:0] gnt;
        logic [3:0] done;
        logic [1:0] sel;
        logic       dreq;
        logic       busy;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [3:0] req, input logic act, input logic dn);
        req_i           = req;
        DMA_Active_i    = act;
        ASSP_DMA_Done_i = dn;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] gnt, input logic [3:0] done,
                              input logic [1:0] sel, input logic dreq, input logic busy);
        check({tag, " gnt"},  32'(gnt_o),     32'(gnt));
        check({tag, " done"}, 32'(done_o),    32'(done));
        check({tag, " sel"},  32'(sel_o),     32'(sel));
        check({tag, " dreq"}, 32'(DMA_REQ_o), 32'(dreq));
        check({tag, " busy"}, 32'(busy_o),    32'(busy));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Single transfer from requester 0; req drops mid-transfer; spurious done/active later.
        //           req     act   dn    gnt     done    sel   dreq  busy
        vecs[0] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1}; // REQ
        vecs[1] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1}; // REQ
        vecs[2] = '{4'b0001, 1'b0, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1}; // REQ
        vecs[3] = '{4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1}; // ACTIVE
        vecs[4] = '{4'b0000, 1'b1, 1'b0, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1}; // ACTIVE
        vecs[5] = '{4'b0000, 1'b0, 1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1}; // DONE
        vecs[6] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1}; // GUARD
        vecs[7] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1}; // GUARD, done ignored
        vecs[8] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // IDLE
        vecs[9] = '{4'b0000, 1'b1, 1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // IDLE, ignored

        do_reset();
        check_outs("reset", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        check("reset err", 32'(err_o), 32'd0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].req, vecs[i].act, vecs[i].dn);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].done,
                       vecs[i].sel, vecs[i].dreq, vecs[i].busy);
        end

        // All four requesting: grants rotate 0,1,2,3,0 with guard gaps between them.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = 4'b0001 << (k % 4);
            drive(4'b1111, 1'b0, 1'b0);
            tick();
            check_outs($sformatf("rr%0d req", k), oh, 4'b0000, 2'(k % 4), 1'b1, 1'b1);
            drive(4'b1111, 1'b1, 1'b0);
            tick();
            check_outs($sformatf("rr%0d act", k), oh, 4'b0000, 2'(k % 4), 1'b0, 1'b1);
            drive(4'b1111, 1'b0, 1'b1);
            tick();
            check_outs($sformatf("rr%0d done", k), oh, oh, 2'(k % 4), 1'b0, 1'b1);
            drive(4'b1111, 1'b0, 1'b0);
            tick();
            check_outs($sformatf("rr%0d g1", k), 4'b0000, 4'b0000, 2'(k % 4), 1'b0, 1'b1);
            tick();
            check_outs($sformatf("rr%0d g2", k), 4'b0000, 4'b0000, 2'(k % 4), 1'b0, 1'b1);
            tick();
            check_outs($sformatf("rr%0d idle", k), 4'b0000, 4'b0000, 2'(k % 4), 1'b0, 1'b0);
        end

        // Done arrives while still in REQ: straight to DONE.
        do_reset();
        drive(4'b0100, 1'b0, 1'b0);
        tick();
        check_outs("skip req", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1);
        drive(4'b0100, 1'b1, 1'b1);
        tick();
        check_outs("skip done", 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b1);
        drive(4'b0000, 1'b0, 1'b0);
        tick();
        check_outs("skip guard", 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b1);

        // Reset in ACTIVE with sel=2, then arbitration restarts from requester 0.
        do_reset();
        drive(4'b0100, 1'b0, 1'b0);
        tick();
        drive(4'b0100, 1'b1, 1'b0);
        tick();
        check_outs("rst pre", 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b1);
        rst_i = 1'b1;
        drive(4'b0100, 1'b1, 1'b1);
        tick();
        check_outs("rst hit", 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
        rst_i = 1'b0;
        drive(4'b0101, 1'b0, 1'b0);
        tick();
        check_outs("rst regrant", 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1);

        // Requester 1 granted but DMA never goes active.
        do_reset();
        drive(4'b0110, 1'b0, 1'b0);
`ifdef DMA_REQ_ARBITER_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) tick();
        check_outs("tmo last req", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b1);
        check("tmo err low", 32'(err_o), 32'd0);
        tick();
        check_outs("tmo guard", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b1);
        check("tmo err set", 32'(err_o), 32'd1);
        tick();
        tick();
        check_outs("tmo idle", 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
        tick();
        check_outs("tmo next", 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1);
        check("tmo err sticky", 32'(err_o), 32'd1);
`else
        for (int c = 0; c < 40; c++) tick();
        check_outs("notmo wait", 4'b0010, 4'b0000, 2'd1, 1'b1, 1'b1);
        check("notmo err", 32'(err_o), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
